multicycle_control: RTL and testbench

//  Main control FSM of the multicycle RV32 core. Sequences the shared ALU, register file and unified

---
 rtl/riscv_ctrl_pkg.sv | 61 ++++++
 rtl/mc_output_decode.sv | 72 +++++++
 rtl/multicycle_control.sv | 98 +++++++++
 tb/tb_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes,
// ALU op codes and datapath mux selects, plus the packed control vector.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control-vector decode. Only pc_write/ir_write look
// at live inputs (mem_ready in FETCH, zero in BEQ); everything else is Moore.
module mc_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMADR, S_EXECI: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.aluop     = ALUOP_FUNC;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_REGA;
        ctrl.alu_src_b  = SRCB_REGB;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32 core: next-state sequencing,
// retired-instruction counter, and the control-vector decode instance.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_next;
  logic   retire;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:  state_next = (func7 == F7_BASE || func7 == F7_ALT) ? S_EXECR : S_TRAP;
          OP_ITYPE:  state_next = (func3 == F3_ADDI) ? S_EXECI : S_TRAP;
          OP_LOAD,
          OP_STORE:  state_next = (func3 == F3_WORD) ? S_MEMADR : S_TRAP;
          OP_BRANCH: state_next = (func3 == F3_BEQ) ? S_BEQ : S_TRAP;
          default:   state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR,
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB,
      S_BEQ:      state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // An instruction retires only on the final hop back to FETCH, so a reset
  // mid-instruction never counts the discarded partial instruction.
  always_comb begin
    retire = 1'b0;
    if (state_next == S_FETCH &&
        (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB || state == S_BEQ))
      retire = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  mc_output_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign aluop      = ctrl.aluop;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction phase script
// model, a vector table, hand-written corner sequences and random traffic.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, aluop;
  logic [31:0] instret;

  logic        pc_write_4, ir_write_4, adr_src_4, mem_read_4, mem_write_4, reg_write_4, illegal_4;
  logic [1:0]  result_src_4, alu_src_a_4, alu_src_b_4, aluop_4;
  logic [3:0]  instret_4;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop(aluop), .illegal(illegal), .instret(instret)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write_4), .ir_write(ir_write_4),
    .adr_src(adr_src_4), .mem_read(mem_read_4), .mem_write(mem_write_4), .reg_write(reg_write_4),
    .result_src(result_src_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
    .aluop(aluop_4), .illegal(illegal_4), .instret(instret_4)
  );

  typedef struct packed {
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, aluop;
    logic       illegal;
  } ctrl_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BAD} kind_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    int         fstall;
    int         mstall;
    int         exp_cycles;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  kind_t m_kind = K_R;
  int    m_p = 0;
  logic [31:0] m_count = '0;

  // Model: an instruction is a script of phases; phase 0 is the fetch, phase 1
  // the decode, and the rest depend on the instruction class.
  function automatic kind_t classify(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    case (op)
      7'b0110011: return (f7 == 7'd0 || f7 == 7'b0100000) ? K_R : K_BAD;
      7'b0010011: return (f3 == 3'd0) ? K_I : K_BAD;
      7'b0000011: return (f3 == 3'b010) ? K_LW : K_BAD;
      7'b0100011: return (f3 == 3'b010) ? K_SW : K_BAD;
      7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_BAD;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic int last_phase(kind_t k);
    case (k)
      K_LW:    return 4;
      K_BEQ:   return 2;
      K_BAD:   return 99;
      default: return 3;
    endcase
  endfunction

  function automatic ctrl_t expect_ctrl();
    ctrl_t c = '0;
    if (m_p == 0) begin
      c.mem_read = 1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
      c.ir_write = mem_ready; c.pc_write = mem_ready;
    end else if (m_p == 1) begin
      c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
    end else if (m_kind == K_BAD) begin
      c.illegal = 1;
    end else if (m_p == 2) begin
      c.alu_src_a = 2'b10;
      case (m_kind)
        K_R:     c.aluop = 2'b10;
        K_BEQ:   begin c.aluop = 2'b01; c.pc_write = zero; end
        default: c.alu_src_b = 2'b01;
      endcase
    end else if (m_p == 3) begin
      case (m_kind)
        K_LW:    begin c.adr_src = 1; c.mem_read = 1; end
        K_SW:    begin c.adr_src = 1; c.mem_write = 1; end
        default: c.reg_write = 1;
      endcase
    end else begin
      c.result_src = 2'b01; c.reg_write = 1;
    end
    return c;
  endfunction

  task automatic model_advance();
    bit waiting;
    if (!rst_n) begin
      m_p = 0; m_count = '0;
    end else if (m_p == 0) begin
      if (mem_ready) m_p = 1;
    end else if (m_p == 1) begin
      m_kind = classify(opcode, func3, func7);
      m_p = 2;
    end else if (m_kind != K_BAD) begin
      waiting = (m_p == 3) && (m_kind == K_LW || m_kind == K_SW) && !mem_ready;
      if (!waiting) begin
        if (m_p == last_phase(m_kind)) begin
          m_p = 0; m_count = m_count + 1;
        end else m_p = m_p + 1;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock: compare both DUTs against the model mid-cycle, then advance.
  task automatic apply_stimulus();
    ctrl_t exp, got, got4;
    @(negedge clk);
    exp  = expect_ctrl();
    got  = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
            result_src, alu_src_a, alu_src_b, aluop, illegal};
    got4 = {pc_write_4, ir_write_4, adr_src_4, mem_read_4, mem_write_4, reg_write_4,
            result_src_4, alu_src_a_4, alu_src_b_4, aluop_4, illegal_4};
    check_output("ctrl", 32'(got), 32'(exp));
    check_output("ctrl_w4", 32'(got4), 32'(exp));
    check_output("instret", instret, m_count);
    check_output("instret_w4", 32'(instret_4), 32'(m_count[3:0]));
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus();
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input vec_t v);
    logic [31:0] start = m_count;
    int cycles = 0, fcnt = 0, mcnt = 0;
    bit done = 0;
    opcode = v.op; func3 = v.f3; func7 = v.f7;
    for (int i = 0; i < 60 && !done; i++) begin
      if (m_p == 0) begin
        mem_ready = (fcnt >= v.fstall); fcnt++;
      end else if (m_p == 3 && (m_kind == K_LW || m_kind == K_SW)) begin
        mem_ready = (mcnt >= v.mstall); mcnt++;
      end else mem_ready = 1'($urandom_range(0, 1));
      zero = (m_p == 2 && m_kind == K_BEQ) ? v.z : 1'($urandom_range(0, 1));
      apply_stimulus();
      cycles++;
      done = (m_count != start);
    end
    if (!done) check_output({v.name, "_timeout"}, 32'd0, 32'd1);
    check_output({v.name, "_cycles"}, 32'(cycles), 32'(v.exp_cycles));
    check_output({v.name, "_retire"}, instret, start + 32'd1);
  endtask

  task automatic pick_random_instr();
    int sel = $urandom_range(0, 9);
    logic [2:0] f3r = 3'($urandom);
    logic [6:0] f7r = 7'($urandom);
    bit legal = ($urandom_range(0, 7) != 0);
    case (sel)
      0, 1:    begin opcode = 7'b0110011; func3 = f3r; func7 = legal ? ($urandom_range(0,1) ? 7'b0100000 : 7'd0) : f7r; end
      2:       begin opcode = 7'b0010011; func3 = legal ? 3'd0 : f3r; func7 = f7r; end
      3, 4:    begin opcode = 7'b0000011; func3 = legal ? 3'b010 : f3r; func7 = f7r; end
      5, 6:    begin opcode = 7'b0100011; func3 = legal ? 3'b010 : f3r; func7 = f7r; end
      7, 8:    begin opcode = 7'b1100011; func3 = legal ? 3'd0 : f3r; func7 = f7r; end
      default: begin opcode = 7'($urandom); func3 = f3r; func7 = f7r; end
    endcase
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t sw_v;
    int trap_cyc = 0;

    vecs.push_back('{"add",      7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 0, 4});
    vecs.push_back('{"sub",      7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 0, 4});
    vecs.push_back('{"and",      7'b0110011, 3'b111, 7'b0000000, 1'b0, 0, 0, 4});
    vecs.push_back('{"or",       7'b0110011, 3'b110, 7'b0000000, 1'b1, 0, 0, 4});
    vecs.push_back('{"addi",     7'b0010011, 3'b000, 7'b1010101, 1'b0, 0, 0, 4});
    vecs.push_back('{"lw_st3",   7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 3, 8});
    vecs.push_back('{"lw",       7'b0000011, 3'b010, 7'b0000000, 1'b1, 0, 0, 5});
    vecs.push_back('{"sw",       7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 0, 4});
    vecs.push_back('{"sw_st2",   7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 2, 6});
    vecs.push_back('{"beq_z1",   7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0, 3});
    vecs.push_back('{"beq_z0",   7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, 0, 3});
    vecs.push_back('{"add_fst2", 7'b0110011, 3'b000, 7'b0000000, 1'b0, 2, 0, 6});

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("reset_instret", instret, 32'd0);
    check_output("reset_illegal", 32'(illegal), 32'd0);
    check_output("reset_fetch_read", 32'(mem_read), 32'd1);

    foreach (vecs[i]) run_instr(vecs[i]);

    // Illegal opcode traps and stays dead until reset.
    opcode = 7'b1111111; func3 = 3'd0; func7 = 7'd0; mem_ready = 1'b1;
    apply_stimulus();
    apply_stimulus();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      apply_stimulus();
    end
    check_output("trap_illegal", 32'(illegal), 32'd1);
    do_reset();
    check_output("trap_rst_illegal", 32'(illegal), 32'd0);
    check_output("trap_rst_instret", instret, 32'd0);
    check_output("trap_rst_fetch", 32'(mem_read), 32'd1);

    // 16 stores on a 4-bit counter wrap it back to zero.
    sw_v = '{"wrap_sw", 7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 0, 4};
    for (int i = 0; i < 15; i++) run_instr(sw_v);
    check_output("wrap_pre_w4", 32'(instret_4), 32'd15);
    run_instr(sw_v);
    check_output("wrap_w4", 32'(instret_4), 32'd0);
    check_output("wrap_w32", instret, 32'd16);

    // Reset lands in the middle of a stalled store.
    opcode = 7'b0100011; func3 = 3'b010; func7 = 7'd0; mem_ready = 1'b1;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    mem_ready = 1'b0;
    check_output("midsw_write", 32'(mem_write), 32'd1);
    apply_stimulus();
    do_reset();
    check_output("midsw_rst_write", 32'(mem_write), 32'd0);
    check_output("midsw_rst_fetch", 32'(mem_read), 32'd1);
    check_output("midsw_rst_instret", instret, 32'd0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = 1'b1;
      if (m_p == 0) pick_random_instr();
      if (m_p >= 2 && m_kind == K_BAD) begin
        trap_cyc++;
        if (trap_cyc > 3) begin rst_n = 1'b0; trap_cyc = 0; end
      end else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      apply_stimulus();
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
